// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU front end: datapath widths, opcode
// values, instruction field layout, decode FSM state type and small helpers.
//
// Instruction word layout (16 bits):
//   [15:12] codop   [11:8] rd   [7:4] rs   [3:0] rt / imm4
//
// Configuration macro (used by files importing this package):
//   DECODE_WB_BYPASS_EN - forward the writeback value to register reads in the
//                         writeback cycle.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W  = 16;
   localparam int NREGS   = 16;
   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 16;

   // Instruction field bit positions (LSB of each 4-bit field).
   localparam int CODOP_LSB = 12;
   localparam int RD_LSB    = 8;
   localparam int RS_LSB    = 4;
   localparam int RT_LSB    = 0;

   // Register-register opcodes.
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   // Register-immediate opcodes.
   localparam logic [3:0] OP_SHLI = 4'd6;
   localparam logic [3:0] OP_SHRI = 4'd7;
   localparam logic [3:0] OP_ANDI = 4'd8;
   localparam logic [3:0] OP_ADDI = 4'd9;
   localparam logic [3:0] OP_SUBI = 4'd10;

   // Packed view of an instruction word; first member is the MSB field.
   typedef struct packed {
      logic [3:0] codop;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
   } instr_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,  // no bundle, nothing held
      ST_HOLD  = 2'd1,  // instruction latched, waiting for its sources
      ST_VALID = 2'd2   // bundle presented to the ALU
   } dec_state_t;

   function automatic logic is_imm(input logic [3:0] codop);
      return (codop >= OP_SHLI) && (codop <= OP_SUBI);
   endfunction

   function automatic logic is_illegal(input logic [3:0] codop);
      return codop > OP_SUBI;
   endfunction

endpackage

// File: rtl/regfile_16x16.sv
// -----------------------------------------------------------------------------
// regfile_16x16
// 16 x 16-bit architectural register file. Two asynchronous read ports, one
// synchronous write port. R0 always reads as zero and ignores writes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (clears all regs)
//   ra_addr / ra_data  read port A
//   rb_addr / rb_data  read port B
//   wr_en, wr_addr,
//   wr_data            write port (writeback)
//
// Configuration macro:
//   DECODE_WB_BYPASS_EN - when defined, a read of the index being written this
//                         cycle returns wr_data combinationally.
// -----------------------------------------------------------------------------
module regfile_16x16
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      ra_data = mem[ra_addr];
`ifdef DECODE_WB_BYPASS_EN
      if (wr_en && (wr_addr == ra_addr)) begin
         ra_data = wr_data;
      end
`endif
      // R0 override comes last so a bypassed write to R0 is never visible.
      if (ra_addr == '0) begin
         ra_data = '0;
      end
   end

   always_comb begin
      rb_data = mem[rb_addr];
`ifdef DECODE_WB_BYPASS_EN
      if (wr_en && (wr_addr == rb_addr)) begin
         rb_data = wr_data;
      end
`endif
      if (rb_addr == '0) begin
         rb_data = '0;
      end
   end

endmodule

// File: rtl/decode_unit.sv
// -----------------------------------------------------------------------------
// decode_unit
// Decode stage of the 16-bit CPU. Splits fetched instructions into fields,
// reads operands from the register file, tracks pending destination writes
// with a busy scoreboard and stalls on read-after-write hazards. Presents a
// registered operand bundle to the ALU.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high; the sender holds its payload stable while valid is
// high and ready is low. instr_ready never depends on instr_valid.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready  fetch side
//   wb_en/wb_addr/wb_data       writeback write port (also clears busy)
//   op_valid/op_ready           ALU side handshake
//   op_codop/op_a/op_b/op_rd    registered operand bundle
//   illegal                     one-cycle pulse after accepting codop > 10
//
// Configuration macro:
//   DECODE_WB_BYPASS_EN - writeback data is forwarded to operand reads and the
//                         hazard on the written index clears in the same
//                         cycle. Undefined: no combinational wb_* -> op_* path,
//                         hazards clear the cycle after the busy bit clears.
// -----------------------------------------------------------------------------
module decode_unit
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [3:0]        op_codop,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [ADDR_W-1:0] op_rd,
   output logic              illegal
);

   dec_state_t        state, state_nx;
   instr_t            held_q;
   instr_t            src;
   logic [NREGS-1:0]  busy, busy_nx, busy_view;
   logic [NREGS-1:0]  wb_mask, set_mask;
   logic [DATA_W-1:0] rd_a, rd_b, operand_b;
   logic              accept, transfer, hazard, src_illegal;
   logic              load, latch, pulse;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   assign op_valid    = (state == ST_VALID);
   assign instr_ready = (state != ST_HOLD) && (!op_valid || op_ready);
   assign accept      = instr_valid && instr_ready;
   assign transfer    = op_valid && op_ready;

   // In HOLD the latched instruction is the one being decoded; otherwise the
   // word on the fetch port is decoded speculatively and used only on accept.
   assign src         = (state == ST_HOLD) ? held_q : instr_t'(instr);
   assign src_illegal = is_illegal(src.codop);

   regfile_16x16 u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (src.rs),
      .ra_data (rd_a),
      .rb_addr (src.rt),
      .rb_data (rd_b),
      .wr_en   (wb_en),
      .wr_addr (wb_addr),
      .wr_data (wb_data)
   );

   assign operand_b = is_imm(src.codop) ? {{(DATA_W-4){1'b0}}, src.rt} : rd_b;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   always_comb begin
      wb_mask = '0;
      if (wb_en) begin
         wb_mask[wb_addr] = 1'b1;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   // The index being written back is already readable through the bypass.
   assign busy_view = busy & ~wb_mask;
`else
   assign busy_view = busy;
`endif

   always_comb begin
      hazard = 1'b0;
      if ((src.rs != '0) && busy_view[src.rs]) begin
         hazard = 1'b1;
      end
      if (!is_imm(src.codop) && (src.rt != '0) && busy_view[src.rt]) begin
         hazard = 1'b1;
      end
      // Illegal instructions read nothing, so they never wait.
      if (src_illegal) begin
         hazard = 1'b0;
      end
   end

   // Set is applied after clear so a same-cycle set of the same index wins.
   always_comb begin
      set_mask = '0;
      if (load && (src.rd != '0)) begin
         set_mask[src.rd] = 1'b1;
      end
      busy_nx = (busy & ~wb_mask) | set_mask;
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      latch    = 1'b0;
      pulse    = 1'b0;
      unique case (state)
         // EMPTY and VALID share the accept path: instr_ready already
         // guarantees the output slot is free (empty or transferring now).
         ST_EMPTY, ST_VALID: begin
            if (accept) begin
               if (src_illegal) begin
                  pulse    = 1'b1;
                  state_nx = ST_EMPTY;
               end else if (hazard) begin
                  latch    = 1'b1;
                  state_nx = ST_HOLD;
               end else begin
                  load     = 1'b1;
                  state_nx = ST_VALID;
               end
            end else if (transfer) begin
               state_nx = ST_EMPTY;
            end
         end
         // op_valid is low in HOLD, so the slot is always free here.
         ST_HOLD: begin
            if (!hazard) begin
               load     = 1'b1;
               state_nx = ST_VALID;
            end
         end
         default: begin
            state_nx = ST_EMPTY;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q   <= '0;
         busy     <= '0;
         illegal  <= 1'b0;
         op_codop <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
      end else begin
         busy    <= busy_nx;
         illegal <= pulse;
         if (latch) begin
            held_q <= src;
         end
         if (load) begin
            op_codop <= src.codop;
            op_a     <= rd_a;
            op_b     <= operand_b;
            op_rd    <= src.rd;
         end
      end
   end

endmodule

// File: tb/tb_decode_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_unit
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model: an ordered queue of accepted instructions whose
// expected operands are computed from a model register array maintained by
// the bench's own writeback engine.
// -----------------------------------------------------------------------------
module tb_decode_unit;
   import cpu_pkg::*;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [3:0]  op_codop;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [3:0]  op_rd;
   logic        illegal;

   decode_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_codop    (op_codop),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_rd       (op_rd),
      .illegal     (illegal)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      int          due;
   } wb_t;

   logic [15:0] exp_q[$];
   wb_t         wb_q[$];
   logic [15:0] m_reg [16];
   int          pend [16];

   function automatic logic [15:0] gen_instr();
      logic [3:0] c, rd, rs, rt;
      if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(11, 15));
      else                           c = 4'($urandom_range(0, 10));
      rd = 4'($urandom_range(0, 7));
      // Keep at most one outstanding writer per register.
      if (pend[rd] > 0) rd = 4'd0;
      rs = 4'($urandom_range(0, 7));
      rt = 4'($urandom_range(0, 7));
      return {c, rd, rs, rt};
   endfunction

   // Random-phase working variables.
   logic [15:0] w, e_a, e_b, rnd;
   logic [3:0]  e_codop, e_rd, e_rs, e_rt;
   logic        exp_illegal, accepted, prev_stall;
   logic [3:0]  s_codop, s_rd;
   logic [15:0] s_a, s_b;
   wb_t         ent;

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      // ---- reset state ----
      rst_n = 1'b0;
      #12;
      check_eq("rst_op_valid", op_valid, 1'b0);
      check_eq("rst_illegal", illegal, 1'b0);
      check_eq("rst_op_a", op_a, 16'h0);
      check_eq("rst_instr_ready", instr_ready, 1'b1);
      check_eq("rst_busy", dut.busy, 16'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // ---- R1=5, R2=3, then add r3,r1,r2 ----
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd5;
      tick();
      wb_addr = 4'd2; wb_data = 16'd3;
      tick();
      wb_en = 1'b0;
      instr_valid = 1'b1; instr = 16'h0312; op_ready = 1'b0;
      tick();
      instr_valid = 1'b0;
      check_eq("add_valid", op_valid, 1'b1);
      check_eq("add_codop", op_codop, 4'd0);
      check_eq("add_a", op_a, 16'd5);
      check_eq("add_b", op_b, 16'd3);
      check_eq("add_rd", op_rd, 4'd3);
      check_eq("add_busy3", dut.busy[3], 1'b1);

      // ---- sub r4,r3,r4 while r3 pending: transfer+accept into HOLD ----
      instr_valid = 1'b1; instr = 16'h1434; op_ready = 1'b1;
      tick();
      instr_valid = 1'b0;
      check_eq("hold_op_valid", op_valid, 1'b0);
      check_eq("hold_instr_ready", instr_ready, 1'b0);
      tick();
      check_eq("hold_still", op_valid, 1'b0);
      wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'd8; op_ready = 1'b0;
      tick();
      wb_en = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
      check_eq("nobyp_extra_stall", op_valid, 1'b0);
      tick();
`endif
      check_eq("sub_valid", op_valid, 1'b1);
      check_eq("sub_codop", op_codop, 4'd1);
      check_eq("sub_a", op_a, 16'd8);
      check_eq("sub_b", op_b, 16'd0);
      check_eq("sub_rd", op_rd, 4'd4);
      check_eq("sub_busy", dut.busy, 16'h0010);

      // ---- stall 3 cycles, then transfer+accept addi r5,r1,7 ----
      instr_valid = 1'b1; instr = 16'h9517;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_valid", op_valid, 1'b1);
         check_eq("stall_a", op_a, 16'd8);
         check_eq("stall_codop", op_codop, 4'd1);
         check_eq("stall_rd", op_rd, 4'd4);
         check_eq("stall_instr_ready", instr_ready, 1'b0);
      end
      op_ready = 1'b1;
      #1;
      check_eq("ready_passthru", instr_ready, 1'b1);
      tick();
      instr_valid = 1'b0;
      check_eq("addi_valid", op_valid, 1'b1);
      check_eq("addi_codop", op_codop, 4'd9);
      check_eq("addi_a", op_a, 16'd5);
      check_eq("addi_b", op_b, 16'd7);
      check_eq("addi_rd", op_rd, 4'd5);
      tick();
      check_eq("drain_valid", op_valid, 1'b0);
      check_eq("busy_45", dut.busy, 16'h0030);

      // ---- illegal codop ----
      instr_valid = 1'b1; instr = 16'hF000;
      tick();
      instr_valid = 1'b0;
      check_eq("ill_pulse", illegal, 1'b1);
      check_eq("ill_no_bundle", op_valid, 1'b0);
      check_eq("ill_busy", dut.busy, 16'h0030);
      tick();
      check_eq("ill_pulse_end", illegal, 1'b0);

      // ---- write to R0 is ignored ----
      wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hBEEF;
      tick();
      wb_en = 1'b0;
      instr_valid = 1'b1; instr = 16'h6000; op_ready = 1'b0;
      tick();
      instr_valid = 1'b0;
      check_eq("r0_valid", op_valid, 1'b1);
      check_eq("r0_a", op_a, 16'h0);
      check_eq("r0_codop", op_codop, 4'd6);
      op_ready = 1'b1;
      tick();

      // ---- reset while in HOLD ----
      instr_valid = 1'b1; instr = 16'h1040;
      tick();
      instr_valid = 1'b0;
      check_eq("pre_rst_hold", instr_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("arst_op_valid", op_valid, 1'b0);
      check_eq("arst_busy", dut.busy, 16'h0);
      check_eq("arst_instr_ready", instr_ready, 1'b1);
      check_eq("arst_reg1", dut.u_rf.mem[1], 16'h0);
      check_eq("arst_codop", op_codop, 4'd0);
      tick();
      rst_n = 1'b1;
      op_ready = 1'b0;
      tick();

      // ---- randomized traffic ----
      for (int i = 0; i < 16; i++) begin
         m_reg[i] = '0;
         pend[i]  = 0;
      end
      exp_illegal = 1'b0;
      accepted    = 1'b0;
      prev_stall  = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (accepted) instr_valid = 1'b0;
         if (!instr_valid && (c < 2500) && ($urandom_range(0, 3) != 0)) begin
            instr = gen_instr();
            instr_valid = 1'b1;
         end
         op_ready = (c >= 2500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if ((wb_q.size() > 0) && (wb_q[0].due <= c)) begin
            wb_en   = 1'b1;
            wb_addr = wb_q[0].addr;
            wb_data = wb_q[0].data;
            void'(wb_q.pop_front());
         end else begin
            wb_en = 1'b0;
         end

         @(negedge clk);
         check_eq("rnd_illegal", illegal, exp_illegal);
         exp_illegal = 1'b0;
         if (prev_stall) begin
            check_eq("rnd_stable", {op_valid, op_codop, op_rd, op_a, op_b},
                     {1'b1, s_codop, s_rd, s_a, s_b});
         end
         prev_stall = op_valid && !op_ready;
         s_codop = op_codop; s_rd = op_rd; s_a = op_a; s_b = op_b;

         if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("rnd_spurious_bundle", 1'b1, 1'b0);
            end else begin
               w = exp_q.pop_front();
               e_codop = w[15:12]; e_rd = w[11:8]; e_rs = w[7:4]; e_rt = w[3:0];
               e_a = (e_rs == 4'd0) ? 16'h0 : m_reg[e_rs];
               if (e_codop <= 4'd5) e_b = (e_rt == 4'd0) ? 16'h0 : m_reg[e_rt];
               else                 e_b = {12'h000, e_rt};
               check_eq("rnd_codop", op_codop, e_codop);
               check_eq("rnd_rd", op_rd, e_rd);
               check_eq("rnd_a", op_a, e_a);
               check_eq("rnd_b", op_b, e_b);
               rnd = 16'($urandom_range(0, 65535));
               ent.addr = e_rd;
               ent.data = rnd;
               ent.due  = c + 1 + int'($urandom_range(0, 3));
               wb_q.push_back(ent);
            end
         end

         accepted = instr_valid && instr_ready;
         if (accepted) begin
            if (instr[15:12] > 4'd10) begin
               exp_illegal = 1'b1;
            end else begin
               exp_q.push_back(instr);
               if (instr[11:8] != 4'd0) pend[instr[11:8]]++;
            end
         end

         if (wb_en) begin
            if (wb_addr != 4'd0) m_reg[wb_addr] = wb_data;
            if (pend[wb_addr] > 0) pend[wb_addr]--;
         end

         @(posedge clk);
         #1;
      end
      wb_en = 1'b0;
      check_eq("rnd_drain_queue", 32'(exp_q.size()), 32'd0);
      check_eq("rnd_drain_fetch", instr_valid && !accepted, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
